// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: state codes, datapath widths,
// song identifiers and the tempo clamp used when a song is loaded.
package song_sequencer_pkg;

  localparam int unsigned TEMPO_W = 26;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned CNT_W   = 3;

  localparam logic SONG_0 = 1'b0;
  localparam logic SONG_1 = 1'b1;

  // Shortest beat period the divider can produce
  localparam logic [TEMPO_W-1:0] MIN_TEMPO = 26'd2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StCountIn = 3'd2,
    StPlay    = 3'd3,
    StPause   = 3'd4,
    StDone    = 3'd5
  } state_e;

  function automatic logic [TEMPO_W-1:0] clamp_tempo(input logic [TEMPO_W-1:0] tempo);
    return (tempo < MIN_TEMPO) ? MIN_TEMPO : tempo;
  endfunction

endpackage

// File: rtl/song_sequencer_beat_divider.sv
// Beat period divider: counts 0..period-1 while enabled, holds otherwise,
// and flags the wrap cycle with a combinational strobe.
module song_sequencer_beat_divider
  import song_sequencer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [TEMPO_W-1:0] i_period,
  output logic               o_strobe
);

  logic [TEMPO_W-1:0] r_count;
  logic               w_wrap;

  // >= rather than == so a stray count above the period still wraps
  assign w_wrap   = (r_count >= (i_period - TEMPO_W'(1)));
  assign o_strobe = i_enable && !i_clear && w_wrap;

  // Counter: clear wins over enable
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_wrap ? '0 : r_count + TEMPO_W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: selects the song, holds the score loader in reset while
// idle, runs a count-in and then paces the score with one beat_en per beat.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LEN0     = 7'd96,
  parameter logic [ADDR_W-1:0] LEN1     = 7'd64,
  parameter logic [CNT_W-1:0]  COUNT_IN = 3'd4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_pause_toggle,
  input  logic               i_song_sel,
  input  logic [TEMPO_W-1:0] i_tempo,
  output logic               o_score_reset,
  output logic               o_song_id,
  output logic               o_beat_en,
  output logic               o_count_in_beat,
  output logic [CNT_W-1:0]   o_beats_left,
  output logic [ADDR_W-1:0]  o_beat_index,
  output logic [2:0]         o_state,
  output logic               o_song_done
);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_song_id;
  logic [TEMPO_W-1:0]  r_tempo_eff;
  logic [ADDR_W-1:0]   r_len;
  logic [CNT_W-1:0]    r_beats_left;
  logic [ADDR_W-1:0]   r_beat_index;
  logic                r_beat_en;
  logic                r_count_in_beat;
  logic                w_strobe;
  logic                w_div_enable;
  logic                w_div_clear;
  logic                w_last_count;
  logic                w_last_beat;

  assign w_div_enable = (r_state == StCountIn) || (r_state == StPlay);
  assign w_div_clear  = (r_state == StLoad);
  assign w_last_count = (r_beats_left == CNT_W'(1));
  assign w_last_beat  = (r_beat_index == (r_len - ADDR_W'(1)));

  song_sequencer_beat_divider u_beat_divider (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_div_clear),
    .i_enable (w_div_enable),
    .i_period (r_tempo_eff),
    .o_strobe (w_strobe)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: start beats everything, final beat beats pause
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StLoad;
      end
      StLoad: begin
        if (i_start)               w_state_next = StLoad;
        else if (COUNT_IN != '0)   w_state_next = StCountIn;
        else                       w_state_next = StPlay;
      end
      StCountIn: begin
        if (i_start)                       w_state_next = StLoad;
        else if (w_strobe && w_last_count) w_state_next = StPlay;
      end
      StPlay: begin
        if (i_start)                      w_state_next = StLoad;
        else if (w_strobe && w_last_beat) w_state_next = StDone;
        else if (i_pause_toggle)          w_state_next = StPause;
      end
      StPause: begin
        if (i_start)             w_state_next = StLoad;
        else if (i_pause_toggle) w_state_next = StPlay;
      end
      StDone: begin
        if (i_start) w_state_next = StLoad;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs decoded from the state register only
  always_comb begin
    o_score_reset = 1'b0;
    o_song_done   = 1'b0;
    unique case (r_state)
      StIdle, StLoad: o_score_reset = 1'b1;
      StDone:         o_song_done   = 1'b1;
      default:        ;
    endcase
  end

  // Song latch, load-time setup, count-in and beat counters, beat pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_song_id       <= 1'b0;
      r_tempo_eff     <= MIN_TEMPO;
      r_len           <= LEN0;
      r_beats_left    <= '0;
      r_beat_index    <= '0;
      r_beat_en       <= 1'b0;
      r_count_in_beat <= 1'b0;
    end else begin
      r_beat_en       <= 1'b0;
      r_count_in_beat <= 1'b0;
      // Entering LOAD only ever happens on an accepted start
      if (w_state_next == StLoad) r_song_id <= i_song_sel;
      unique case (r_state)
        StLoad: begin
          r_tempo_eff  <= clamp_tempo(i_tempo);
          r_len        <= (r_song_id == SONG_0) ? LEN0 : LEN1;
          r_beat_index <= '0;
          r_beats_left <= COUNT_IN;
        end
        StCountIn: begin
          if (w_strobe && !i_start) begin
            r_count_in_beat <= 1'b1;
            r_beats_left    <= r_beats_left - CNT_W'(1);
          end
        end
        StPlay: begin
          if (w_strobe && !i_start) begin
            r_beat_en    <= 1'b1;
            r_beat_index <= r_beat_index + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_song_id       = r_song_id;
  assign o_beat_en       = r_beat_en;
  assign o_count_in_beat = r_count_in_beat;
  assign o_beats_left    = r_beats_left;
  assign o_beat_index    = r_beat_index;
  assign o_state         = r_state;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a table of one-cycle input pulses with
// the packed output state expected a fixed number of edges later, then
// hand-written sequences for pause, same-cycle events and reset.
module tb_song_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CI   = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_PAUS = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pause_toggle = 1'b0;
  logic        i_song_sel = 1'b0;
  logic [25:0] i_tempo = 26'd10;
  logic        o_score_reset, o_song_id, o_beat_en, o_count_in_beat, o_song_done;
  logic [2:0]  o_beats_left, o_state;
  logic [6:0]  o_beat_index;

  int checks = 0;
  int errors = 0;

  song_sequencer dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_pause_toggle  (i_pause_toggle),
    .i_song_sel      (i_song_sel),
    .i_tempo         (i_tempo),
    .o_score_reset   (o_score_reset),
    .o_song_id       (o_song_id),
    .o_beat_en       (o_beat_en),
    .o_count_in_beat (o_count_in_beat),
    .o_beats_left    (o_beats_left),
    .o_beat_index    (o_beat_index),
    .o_state         (o_state),
    .o_song_done     (o_song_done)
  );

  always #5 clk = ~clk;

  // {state, score_reset, song_id, beat_en, count_in_beat, beats_left, beat_index, song_done}
  function automatic logic [17:0] pk(input logic [2:0] st, input logic sr, input logic id,
                                     input logic be, input logic cib, input logic [2:0] bl,
                                     input logic [6:0] bi, input logic dn);
    return {st, sr, id, be, cib, bl, bi, dn};
  endfunction

  typedef struct {
    logic        start;
    logic        pause;
    logic        sel;
    logic [25:0] tempo;
    int          gap;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[30];

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic st, input logic ps, input logic sel, input logic [25:0] tmp);
    i_start        = st;
    i_pause_toggle = ps;
    i_song_sel     = sel;
    i_tempo        = tmp;
    tick(1);
    i_start        = 1'b0;
    i_pause_toggle = 1'b0;
  endtask

  task automatic chk(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = pk(o_state, o_score_reset, o_song_id, o_beat_en, o_count_in_beat, o_beats_left,
             o_beat_index, o_song_done);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual st=%0d sr=%b id=%b be=%b cib=%b bl=%0d bi=%0d dn=%b required st=%0d sr=%b id=%b be=%b cib=%b bl=%0d bi=%0d dn=%b",
               name, act[17:15], act[14], act[13], act[12], act[11], act[10:8], act[7:1], act[0],
               exp[17:15], exp[14], exp[13], exp[12], exp[11], exp[10:8], exp[7:1], exp[0]);
    end
  endtask

  initial begin
    // Song 1 (64 beats) at tempo 10 through to DONE
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 26'd10, 0,   pk(S_LOAD, 1, 1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 26'd10, 0,   pk(S_CI,   0, 1, 0, 0, 4, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 26'd10, 9,   pk(S_CI,   0, 1, 0, 1, 3, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 26'd10, 0,   pk(S_CI,   0, 1, 0, 0, 3, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 26'd10, 28,  pk(S_PLAY, 0, 1, 0, 1, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 26'd10, 9,   pk(S_PLAY, 0, 1, 1, 0, 0, 1, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 26'd10, 9,   pk(S_PLAY, 0, 1, 1, 0, 0, 2, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 26'd10, 0,   pk(S_PLAY, 0, 1, 0, 0, 0, 2, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 26'd10, 608, pk(S_PLAY, 0, 1, 1, 0, 0, 63, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 26'd10, 9,   pk(S_DONE, 0, 1, 1, 0, 0, 64, 1)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 26'd10, 0,   pk(S_DONE, 0, 1, 0, 0, 0, 64, 1)};
    // Restart from DONE, song 0, tempo 0 clamps to 2
    vecs[11] = '{1'b1, 1'b0, 1'b0, 26'd0,  0,   pk(S_LOAD, 1, 0, 0, 0, 0, 64, 0)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 26'd0,  0,   pk(S_CI,   0, 0, 0, 0, 4, 0, 0)};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 26'd0,  1,   pk(S_CI,   0, 0, 0, 1, 3, 0, 0)};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 26'd0,  0,   pk(S_CI,   0, 0, 0, 0, 3, 0, 0)};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 26'd0,  4,   pk(S_PLAY, 0, 0, 0, 1, 0, 0, 0)};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 26'd0,  1,   pk(S_PLAY, 0, 0, 1, 0, 0, 1, 0)};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 26'd0,  0,   pk(S_PLAY, 0, 0, 0, 0, 0, 1, 0)};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 26'd0,  0,   pk(S_PLAY, 0, 0, 1, 0, 0, 2, 0)};
    // Restart from PLAY with tempo 1, also clamped to 2
    vecs[19] = '{1'b1, 1'b0, 1'b0, 26'd1,  0,   pk(S_LOAD, 1, 0, 0, 0, 0, 2, 0)};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 26'd1,  0,   pk(S_CI,   0, 0, 0, 0, 4, 0, 0)};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 26'd1,  1,   pk(S_CI,   0, 0, 0, 1, 3, 0, 0)};
    // Restart at beat 20 with song_sel flipped; later tempo change is ignored
    vecs[22] = '{1'b1, 1'b0, 1'b1, 26'd10, 0,   pk(S_LOAD, 1, 1, 0, 0, 3, 0, 0)};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 26'd10, 0,   pk(S_CI,   0, 1, 0, 0, 4, 0, 0)};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 26'd10, 239, pk(S_PLAY, 0, 1, 1, 0, 0, 20, 0)};
    vecs[25] = '{1'b0, 1'b0, 1'b1, 26'd10, 4,   pk(S_PLAY, 0, 1, 0, 0, 0, 20, 0)};
    vecs[26] = '{1'b1, 1'b0, 1'b0, 26'd10, 0,   pk(S_LOAD, 1, 0, 0, 0, 0, 20, 0)};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 26'd10, 0,   pk(S_CI,   0, 0, 0, 0, 4, 0, 0)};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 26'd3,  9,   pk(S_CI,   0, 0, 0, 1, 3, 0, 0)};
    vecs[29] = '{1'b0, 1'b0, 1'b0, 26'd3,  9,   pk(S_CI,   0, 0, 0, 1, 2, 0, 0)};

    tick(3);
    i_reset = 1'b0;
    chk("reset_state", pk(S_IDLE, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 30; i++) begin
      pulse(vecs[i].start, vecs[i].pause, vecs[i].sel, vecs[i].tempo);
      tick(vecs[i].gap);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // pause_toggle is ignored in COUNTIN
    pulse(1'b0, 1'b1, 1'b0, 26'd10);
    chk("ci_ignores_pause", pk(S_CI, 0, 0, 0, 0, 2, 0, 0));

    // Pause at divider=3, hold 50 cycles, resume: next beat 7 cycles later
    pulse(1'b1, 1'b0, 1'b0, 26'd10);
    chk("pause_load", pk(S_LOAD, 1, 0, 0, 0, 2, 0, 0));
    tick(1);
    tick(50);
    chk("pre_pause_beat", pk(S_PLAY, 0, 0, 1, 0, 0, 1, 0));
    tick(3);
    pulse(1'b0, 1'b1, 1'b0, 26'd10);
    chk("pause_enter", pk(S_PAUS, 0, 0, 0, 0, 0, 1, 0));
    tick(49);
    chk("pause_hold", pk(S_PAUS, 0, 0, 0, 0, 0, 1, 0));
    pulse(1'b0, 1'b1, 1'b0, 26'd10);
    chk("resume", pk(S_PLAY, 0, 0, 0, 0, 0, 1, 0));
    tick(5);
    chk("resume_no_beat_yet", pk(S_PLAY, 0, 0, 0, 0, 0, 1, 0));
    tick(1);
    chk("resume_beat", pk(S_PLAY, 0, 0, 1, 0, 0, 2, 0));

    // Strobe and pause_toggle in the same PLAY cycle
    tick(9);
    pulse(1'b0, 1'b1, 1'b0, 26'd10);
    chk("strobe_pause", pk(S_PAUS, 0, 0, 1, 0, 0, 3, 0));
    tick(1);
    chk("strobe_pause_after", pk(S_PAUS, 0, 0, 0, 0, 0, 3, 0));

    // start together with pause_toggle goes to LOAD
    pulse(1'b1, 1'b1, 1'b1, 26'd2);
    chk("start_pause", pk(S_LOAD, 1, 1, 0, 0, 0, 3, 0));

    // Final strobe together with pause_toggle goes to DONE
    tick(1);
    tick(135);
    pulse(1'b0, 1'b1, 1'b1, 26'd2);
    chk("final_pause", pk(S_DONE, 0, 1, 1, 0, 0, 64, 1));
    pulse(1'b0, 1'b1, 1'b1, 26'd2);
    chk("done_ignores_pause", pk(S_DONE, 0, 1, 0, 0, 0, 64, 1));

    // Reset in COUNTIN
    pulse(1'b1, 1'b0, 1'b1, 26'd2);
    tick(1);
    tick(3);
    chk("ci_before_reset", pk(S_CI, 0, 1, 0, 0, 3, 0, 0));
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    chk("reset_in_ci", pk(S_IDLE, 1, 0, 0, 0, 0, 0, 0));

    // Reset in PAUSE
    pulse(1'b1, 1'b0, 1'b1, 26'd10);
    tick(1);
    tick(45);
    pulse(1'b0, 1'b1, 1'b1, 26'd10);
    chk("pause_before_reset", pk(S_PAUS, 0, 1, 0, 0, 0, 0, 0));
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    chk("reset_in_pause", pk(S_IDLE, 1, 0, 0, 0, 0, 0, 0));
    pulse(1'b0, 1'b1, 1'b1, 26'd10);
    tick(3);
    chk("idle_ignores_pause", pk(S_IDLE, 1, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
